i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Stereo I2S master transmitter that drives the board's audio codec pins i2s_mclk, i2s_sclk, i2s_lrclk and i2s_sdata.
- Sits directly upstream of those top-level pins inside fpga_standalone_top. It consumes left/right sample pairs from the audio source over a valid/ready handshake.
- Produces MCLK, bit clock, word clock and serial data from the single ~49.152 MHz system clock. Rates are 12.288 MHz MCLK, 3.072 MHz SCLK and 48 kHz LRCLK.

Parameters:
- SAMPLE_WIDTH, 24: bits per channel sample, 1..31. Left-justified in a 32-bit slot.
- CLK_PER_MCLK_LOG2, 2: log2 of clk cycles per MCLK period.
- MCLK_PER_SCLK_LOG2, 2: log2 of MCLK periods per SCLK period.

Ports:
- clk  in  1  system clock.
- arst  in  1  asynchronous reset, active-low (asserted while 0).
- s_valid  in  1  sample pair valid.
- s_ready  out  1  block can accept a sample pair.
- s_left  in  SAMPLE_WIDTH  left sample, two's complement.
- s_right  in  SAMPLE_WIDTH  right sample, two's complement.
- i2s_mclk  out  1  codec master clock.
- i2s_sclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data.
- underrun  out  1  one-cycle pulse when a frame starts with no pending pair.
- underrun_cnt  out  16  saturating count of underruns.

Behaviour:
- Free-running counter c, width W = CLK_PER_MCLK_LOG2 + MCLK_PER_SCLK_LOG2 + 6.
  - Let A = CLK_PER_MCLK_LOG2, B = A + MCLK_PER_SCLK_LOG2.
  - c wraps from 2^W-1 to 0; with defaults, 1024 clk per frame.
- All pin outputs come straight from flops; no combinational path to pins. In the cycle where the counter holds c:
  - i2s_mclk = c[A-1].
  - i2s_sclk = c[B-1].
  - i2s_lrclk = c[W-1].
  - slot b = c[W-1:B], range 0..63.
- Data slots (standard I2S, one-bit delay after LRCLK edge):
  - sdata changes only at c[B-1:0]==0, i.e. the falling edge of sclk. It is stable across the rising edge.
  - Slots 1..SAMPLE_WIDTH carry active_left, MSB first.
  - Slots 33..32+SAMPLE_WIDTH carry active_right, MSB first.
  - All other slots, including 0 and 32, output 0.
- One-entry pending buffer, pend_full:
  - s_ready = !pend_full.
  - Transfer occurs on a clock edge with s_valid && s_ready; this sets pend_full and captures the pair.
- Frame load happens on the edge where c advances 2^W-1 -> 0:
  - If pend_full: active ← pending and pend_full is cleared.
  - Else: active ← 0, underrun = 1 for the cycle with c==0, and underrun_cnt increments, saturating at 0xFFFF.
- Simultaneous events:
  - A transfer on the load edge while the buffer is empty goes into pending, not active. That frame still counts as an underrun.
  - s_ready may rise in the cycle after a load.
- Reset (arst=0, asynchronous) clears c, pending, active, pend_full, underrun_cnt and all outputs to 0, and forces s_ready to 0.
  - After release, s_ready = 1 from the first clock.
  - Reset mid-frame discards the pending pair. Pins drop to 0 immediately without waiting for a clock.
- s_left/s_right are sampled only on the transfer edge. Input changes while s_ready=0 are ignored.

Decomposition:
- Package psoc_audio_pkg holds:
  - SLOT_BITS = 32 and FRAME_SLOTS = 64.
  - Default SAMPLE_WIDTH = 24.
  - The clk/MCLK/SCLK ratio constants, shared with the top level and the testbench.
- Sub-module i2s_clk_gen: holds counter c and produces registered mclk/sclk/lrclk, plus the strobes frame_load (c==2^W-1) and bit_shift (c[B-1:0]==2^B-1), each one cycle ahead.
- i2s_tx keeps the handshake, buffers, shift register and underrun logic.

Test Plan:
- Reset: hold arst=0 for 5 cycles, then release → all outputs 0 during reset; s_ready=1 on the first clock after release; counters cleared.
- Clock ratios: free-run 4096 clk → mclk period 4 clk, sclk period 16 clk, lrclk period 1024 clk with 50% duty; lrclk falls only at c=0.
- Data: send L=0xABCDEF, R=0x123456 once, then keep s_valid low. Sample sdata on rising sclk → frame after load decodes 0xABCDEF, then 0x123456. Slots 0, 25..32 and 57..63 read 0. The next frame is all zero.
- Underrun: leave s_valid=0 for 3 frames → underrun pulses exactly 3 times at c==0, underrun_cnt=3, sdata constantly 0.
- Backpressure: hold s_valid=1 with three distinct pairs → s_ready drops after the first acceptance. One pair is accepted per frame, in order, with no loss or duplication.
- Mid-frame reset: assert arst at c=500 with pend_full=1 → pins 0 asynchronously. After release, the first frame underruns, proving the pending pair was dropped.

Source files
------------

// File: rtl/psoc_audio_pkg.sv
// Shared constants and helpers for the audio path: I2S frame geometry and
// the default clk/MCLK/SCLK ratios used by the transmitter and its bench.
package psoc_audio_pkg;

    // Frame geometry: two 32-bit slots per channel pair, one bit per slot.
    localparam int SLOT_BITS        = 32;
    localparam int FRAME_SLOTS      = 64;
    localparam int FRAME_SLOTS_LOG2 = 6;

    // Default sample width and clock ratios
    // (49.152 MHz clk -> 12.288 MHz MCLK -> 3.072 MHz SCLK -> 48 kHz LRCLK).
    localparam int DEF_SAMPLE_WIDTH       = 24;
    localparam int DEF_CLK_PER_MCLK_LOG2  = 2;
    localparam int DEF_MCLK_PER_SCLK_LOG2 = 2;

    // Width of the free-running frame counter for a given ratio pair.
    function automatic int counter_width(input int clk_per_mclk_log2,
                                         input int mclk_per_sclk_log2);
        return clk_per_mclk_log2 + mclk_per_sclk_log2 + FRAME_SLOTS_LOG2;
    endfunction

    // Build one 32-bit slot: a leading zero bit (the I2S one-bit delay),
    // then the sample MSB first, zero padded at the LSB end.
    function automatic logic [SLOT_BITS-1:0] slot_word(
        input logic [SLOT_BITS-2:0] sample,
        input int unsigned          width
    );
        return {1'b0, sample} << (SLOT_BITS - 1 - width);
    endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Frame counter and clock generator: derives registered MCLK, SCLK and
// LRCLK from one free-running counter, plus one-cycle-early strobes that
// let the transmitter update data on the same edge the clocks change.
module i2s_clk_gen
    import psoc_audio_pkg::*;
#(
    parameter int CLK_PER_MCLK_LOG2  = DEF_CLK_PER_MCLK_LOG2,
    parameter int MCLK_PER_SCLK_LOG2 = DEF_MCLK_PER_SCLK_LOG2
) (
    input  logic clk,
    input  logic arst,
    output logic mclk,
    output logic sclk,
    output logic lrclk,
    output logic frame_load,
    output logic bit_shift
);

    localparam int A = CLK_PER_MCLK_LOG2;
    localparam int B = CLK_PER_MCLK_LOG2 + MCLK_PER_SCLK_LOG2;
    localparam int W = counter_width(CLK_PER_MCLK_LOG2, MCLK_PER_SCLK_LOG2);

    logic [W-1:0] c;
    logic [W-1:0] c_next;

    assign c_next = c + W'(1);

    // Advance the counter and register every output from the next count,
    // so each output matches the count held in the same cycle.
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of c regardless of statement order.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            c          <= '0;
            mclk       <= 1'b0;
            sclk       <= 1'b0;
            lrclk      <= 1'b0;
            frame_load <= 1'b0;
            bit_shift  <= 1'b0;
        end else begin
            c          <= c_next;
            mclk       <= c_next[A-1];
            sclk       <= c_next[B-1];
            lrclk      <= c_next[W-1];
            frame_load <= (c_next == '1);
            bit_shift  <= (c_next[B-1:0] == '1);
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S master transmitter. Accepts left/right pairs over valid/ready
// into a one-entry pending buffer, loads them into a frame shift register
// at each frame boundary and shifts one bit per SCLK period onto i2s_sdata.
// Frames that start with no pending pair send silence and count an underrun.
module i2s_tx
    import psoc_audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH       = DEF_SAMPLE_WIDTH,
    parameter int CLK_PER_MCLK_LOG2  = DEF_CLK_PER_MCLK_LOG2,
    parameter int MCLK_PER_SCLK_LOG2 = DEF_MCLK_PER_SCLK_LOG2
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    output logic                    i2s_mclk,
    output logic                    i2s_sclk,
    output logic                    i2s_lrclk,
    output logic                    i2s_sdata,
    output logic                    underrun,
    output logic [15:0]             underrun_cnt
);

    localparam int SAMPLE_BITS = SLOT_BITS - 1;

    logic                    frame_load;
    logic                    bit_shift;
    logic                    pend_full;
    logic [SAMPLE_WIDTH-1:0] pend_left;
    logic [SAMPLE_WIDTH-1:0] pend_right;
    logic [FRAME_SLOTS-2:0]  shreg;
    logic [FRAME_SLOTS-1:0]  load_frame;
    logic [SAMPLE_BITS-1:0]  left_ext;
    logic [SAMPLE_BITS-1:0]  right_ext;
    logic                    transfer;

    i2s_clk_gen #(
        .CLK_PER_MCLK_LOG2 (CLK_PER_MCLK_LOG2),
        .MCLK_PER_SCLK_LOG2(MCLK_PER_SCLK_LOG2)
    ) u_clk_gen (
        .clk       (clk),
        .arst      (arst),
        .mclk      (i2s_mclk),
        .sclk      (i2s_sclk),
        .lrclk     (i2s_lrclk),
        .frame_load(frame_load),
        .bit_shift (bit_shift)
    );

    // Ready is held low while reset is asserted and otherwise tracks the
    // pending buffer, so a pair can be accepted on the first clock after
    // release.
    assign s_ready  = arst && !pend_full;
    assign transfer = s_valid && s_ready;

    assign left_ext  = SAMPLE_BITS'(pend_left);
    assign right_ext = SAMPLE_BITS'(pend_right);

    // Assemble the next frame: the pending pair if present, else silence.
    // NOTE: load_frame gets a default before the conditional so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        load_frame = '0;
        if (pend_full) begin
            load_frame = {slot_word(left_ext, SAMPLE_WIDTH),
                          slot_word(right_ext, SAMPLE_WIDTH)};
        end
    end

    // Pending buffer: filled by a handshake, emptied by a frame load.
    // A handshake and a load never coincide while full because ready is low.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            pend_full  <= 1'b0;
            pend_left  <= '0;
            pend_right <= '0;
        end else begin
            if (frame_load && pend_full) begin
                pend_full <= 1'b0;
            end
            if (transfer) begin
                pend_full  <= 1'b1;
                pend_left  <= s_left;
                pend_right <= s_right;
            end
        end
    end

    // Frame shift register: load at the frame boundary (slot 0 goes straight
    // to the pin), otherwise shift one slot at each SCLK falling edge.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            shreg     <= '0;
            i2s_sdata <= 1'b0;
        end else if (frame_load) begin
            shreg     <= load_frame[FRAME_SLOTS-2:0];
            i2s_sdata <= load_frame[FRAME_SLOTS-1];
        end else if (bit_shift) begin
            shreg     <= {shreg[FRAME_SLOTS-3:0], 1'b0};
            i2s_sdata <= shreg[FRAME_SLOTS-2];
        end
    end

    // Underrun pulse for the first cycle of a frame that had no pending
    // pair, plus a saturating event counter.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            underrun <= frame_load && !pend_full;
            if (frame_load && !pend_full && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx. A frame-level reference model predicts
// every pin each cycle from the cycle count since reset, and a serial
// decoder reassembles the samples seen on rising SCLK for scenario checks.
module tb_i2s_tx;
    import psoc_audio_pkg::*;

    localparam int SW   = DEF_SAMPLE_WIDTH;
    localparam int A    = DEF_CLK_PER_MCLK_LOG2;
    localparam int B    = DEF_CLK_PER_MCLK_LOG2 + DEF_MCLK_PER_SCLK_LOG2;
    localparam int N    = (1 << B) * FRAME_SLOTS;
    localparam int SDIV = 1 << B;

    logic          clk = 1'b0;
    logic          arst = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [SW-1:0] s_left = '0;
    logic [SW-1:0] s_right = '0;
    logic          i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdata, underrun;
    logic [15:0]   underrun_cnt;

    always #5 clk = ~clk;

    i2s_tx dut (
        .clk         (clk),
        .arst        (arst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .i2s_mclk    (i2s_mclk),
        .i2s_sclk    (i2s_sclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state (frame-level behaviour).
    int            k;
    int            cyc;
    bit            m_full;
    bit            m_xfer;
    bit            m_upulse;
    int            m_ucnt;
    logic [SW-1:0] m_pl, m_pr, m_al, m_ar;

    // Decoder / monitor state.
    logic [63:0]   rx_bits;
    logic [SW-1:0] rx_l[$];
    logic [SW-1:0] rx_r[$];
    bit            rx_zero_ok[$];
    int            upulse_seen;
    int            sdata_ones;
    logic          prev_lrclk;

    task automatic model_reset();
        k = 0; cyc = 0; m_full = 0; m_xfer = 0; m_upulse = 0; m_ucnt = 0;
        m_pl = '0; m_pr = '0; m_al = '0; m_ar = '0;
        rx_bits = '0; rx_l.delete(); rx_r.delete(); rx_zero_ok.delete();
        upulse_seen = 0; sdata_ones = 0; prev_lrclk = 1'b0;
    endtask

    // Expected serial bit for the current count: slot 0 and 32 are the
    // one-bit delay, samples MSB first after them, zero elsewhere.
    function automatic int exp_sdata();
        int slot = k / SDIV;
        if (slot >= 1 && slot <= SW) return int'((m_al >> (SW - slot)) & 1);
        if (slot >= 33 && slot <= 32 + SW) return int'((m_ar >> (SW - (slot - 32))) & 1);
        return 0;
    endfunction

    task automatic check_pins();
        check("mclk", i2s_mclk, (k / (1 << (A - 1))) % 2);
        check("sclk", i2s_sclk, (k / (1 << (B - 1))) % 2);
        check("lrclk", i2s_lrclk, k / (N / 2));
        check("sdata", i2s_sdata, exp_sdata());
        check("underrun", underrun, m_upulse);
        check("underrun_cnt", underrun_cnt, m_ucnt);
        check("s_ready", s_ready, !m_full);
    endtask

    // One clock: advance the model with the inputs that were stable at the
    // edge, then compare all outputs and feed the decoder.
    task automatic step();
        bit xfer;
        bit at_load;
        @(posedge clk);
        xfer    = s_valid && !m_full;
        at_load = (k == N - 1);
        m_upulse = 0;
        if (at_load) begin
            if (m_full) begin
                m_al = m_pl; m_ar = m_pr; m_full = 0;
            end else begin
                m_al = '0; m_ar = '0; m_upulse = 1;
                if (m_ucnt < 16'hFFFF) m_ucnt++;
            end
        end
        if (xfer) begin
            m_pl = s_left; m_pr = s_right; m_full = 1;
        end
        m_xfer = xfer;
        k   = (k + 1) % N;
        cyc++;
        #1;
        check_pins();
        if (prev_lrclk && !i2s_lrclk) check("lrclk_fall_at_c0", k, 0);
        prev_lrclk = i2s_lrclk;
        if (underrun) upulse_seen++;
        if (i2s_sdata) sdata_ones++;
        if (k % SDIV == SDIV / 2) rx_bits[63 - k / SDIV] = i2s_sdata;
        if (k == N - 1) begin
            bit zok = 1;
            for (int s = 0; s < 64; s++) begin
                bit data_slot = (s >= 1 && s <= SW) || (s >= 33 && s <= 32 + SW);
                if (!data_slot && rx_bits[63 - s]) zok = 0;
            end
            rx_l.push_back(rx_bits[62 -: SW]);
            rx_r.push_back(rx_bits[30 -: SW]);
            rx_zero_ok.push_back(zok);
            rx_bits = '0;
        end
    endtask

    // Assert reset asynchronously (pins must drop without a clock), hold
    // it for five cycles, release between edges and restart the model.
    task automatic do_reset();
        arst = 1'b0;
        #1;
        check("rst_async_mclk", i2s_mclk, 0);
        check("rst_async_sclk", i2s_sclk, 0);
        check("rst_async_lrclk", i2s_lrclk, 0);
        check("rst_async_sdata", i2s_sdata, 0);
        check("rst_async_ready", s_ready, 0);
        repeat (5) @(posedge clk);
        #1;
        check("rst_hold_pins", {i2s_mclk, i2s_sclk, i2s_lrclk, i2s_sdata, underrun}, 0);
        check("rst_hold_cnt", underrun_cnt, 0);
        check("rst_hold_ready", s_ready, 0);
        @(negedge clk);
        arst = 1'b1;
        model_reset();
    endtask

    task automatic run_until(input int last_cyc);
        while (cyc < last_cyc) step();
    endtask

    logic [SW-1:0] bp_l[3];
    logic [SW-1:0] bp_r[3];
    int            acc_cyc[$];
    int            idx;

    initial begin
        // Reset and first-clock readiness.
        do_reset();
        step();
        check("ready_first_clock", s_ready, 1);

        // Single known pair, then idle: frame 1 carries it, frame 2 is silent.
        do_reset();
        s_valid = 1'b1; s_left = 24'hABCDEF; s_right = 24'h123456;
        step();
        check("data_accepted", m_xfer, 1);
        s_valid = 1'b0; s_left = '1; s_right = '1;
        run_until(3 * N);
        check("data_frames", rx_l.size(), 3);
        check("data_f0_left", rx_l[0], 0);
        check("data_f1_left", rx_l[1], 24'hABCDEF);
        check("data_f1_right", rx_r[1], 24'h123456);
        check("data_f1_zero_slots", rx_zero_ok[1], 1);
        check("data_f2_left", rx_l[2], 0);
        check("data_f2_right", rx_r[2], 0);
        check("data_underruns", upulse_seen, 2);

        // Three idle frames: three underruns, nothing on sdata.
        do_reset();
        run_until(3 * N + 4);
        check("idle_pulses", upulse_seen, 3);
        check("idle_cnt", underrun_cnt, 3);
        check("idle_sdata_ones", sdata_ones, 0);

        // Backpressure: valid held with three distinct pairs.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bp_l[i] = SW'($urandom) ^ SW'(i + 1);
            bp_r[i] = SW'($urandom) ^ SW'((i + 1) << 4);
        end
        acc_cyc.delete();
        idx = 0;
        s_valid = 1'b1; s_left = bp_l[0]; s_right = bp_r[0];
        while (cyc < 4 * N) begin
            step();
            if (m_xfer) begin
                acc_cyc.push_back(cyc);
                if (idx == 0) check("bp_ready_drop", s_ready, 0);
                idx++;
                if (idx < 3) begin
                    s_left = bp_l[idx]; s_right = bp_r[idx];
                end else begin
                    s_valid = 1'b0;
                end
            end
        end
        check("bp_accepts", acc_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("bp_accept_frame", (acc_cyc[i] - 1) / N, i);
            check("bp_left", rx_l[i + 1], bp_l[i]);
            check("bp_right", rx_r[i + 1], bp_r[i]);
        end

        // Randomised traffic against the model.
        do_reset();
        while (cyc < 6 * N) begin
            s_valid = ($urandom_range(0, 999) < 2);
            s_left  = SW'($urandom);
            s_right = SW'($urandom);
            step();
        end
        s_valid = 1'b0;

        // Mid-frame reset with a pair pending: the pair must be dropped.
        do_reset();
        s_valid = 1'b1; s_left = 24'h5A5A5A; s_right = 24'hA5A5A5;
        step();
        s_valid = 1'b0;
        run_until(500);
        check("mid_pend_full", s_ready, 0);
        do_reset();
        run_until(N + 4);
        check("mid_underrun_cnt", underrun_cnt, 1);
        check("mid_pulses", upulse_seen, 1);
        check("mid_sdata_ones", sdata_ones, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
